freq_counter: RTL and testbench



---
 rtl/freq_counter_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/freq_counter.sv | 94 +++++++++
 tb/tb_freq_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared types and helpers for the gated frequency meter.
// State encodings are plain constants so older blocks can reuse them.
package freq_counter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE    = 1'b0;
  localparam state_t MEASURE = 1'b1;

  // Gate counter only has to hold GATE_CYCLES-1, so clog2 is always wide enough.
  function automatic int gate_cnt_width(input int gate_cycles);
    return $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// Emits a one-cycle rise pulse per synchronized low-to-high transition of d.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_counter.sv
// Gated frequency meter: counts rising edges of sig_in over GATE_CYCLES
// clk_in cycles and publishes the saturating result with a valid pulse.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last result
// MEASURE | gate window running, edges accumulated into edge_cnt
module freq_counter
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 count_valid,
  output logic                 busy,
  output logic                 overflow
);

  localparam int                   GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0]        GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state_q;
  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 ovf_flag;
  logic                 rise;
  logic                 at_max;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .d       (sig_in),
    .rise    (rise)
  );

  assign at_max = (edge_cnt == CNT_MAX);
  assign busy   = (state_q == MEASURE);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_flag    <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= MEASURE;
            gate_cnt <= GATE_LOAD;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
          end
        end
        MEASURE: begin
          if (gate_cnt == '0) begin
            // A rise in the final cycle belongs to the ending window only.
            count       <= (at_max && rise) ? CNT_MAX : edge_cnt + CNT_WIDTH'(rise);
            overflow    <= ovf_flag | (at_max & rise);
            count_valid <= 1'b1;
            if (continuous) begin
              gate_cnt <= GATE_LOAD;
              edge_cnt <= '0;
              ovf_flag <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
            if (rise) begin
              if (at_max) ovf_flag <= 1'b1;
              else        edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter: a default-parameter instance (a) and a
// narrow-counter, short-gate instance (s) driven by a square-wave generator.
module tb_freq_counter;

  logic        clk_in = 1'b0;
  logic        reset_n_a, sig_a, start_a, cont_a;
  logic [15:0] count_a;
  logic        valid_a, busy_a, ovf_a;
  logic        reset_n_s, sig_s, start_s, cont_s;
  logic [3:0]  count_s;
  logic        valid_s, busy_s, ovf_s;

  int n_cmp = 0;
  int n_bad = 0;
  int per_a = 0, ph_a = 0;
  int per_s = 0, ph_s = 0;
  int vld_a = 0;
  int waited, snap;

  always #5 clk_in = ~clk_in;

  freq_counter dut_a (
    .clk_in (clk_in), .reset_n (reset_n_a), .sig_in (sig_a), .start (start_a),
    .continuous (cont_a), .count (count_a), .count_valid (valid_a),
    .busy (busy_a), .overflow (ovf_a)
  );

  freq_counter #(.GATE_CYCLES (100), .CNT_WIDTH (4), .SYNC_STAGES (2)) dut_s (
    .clk_in (clk_in), .reset_n (reset_n_s), .sig_in (sig_s), .start (start_s),
    .continuous (cont_s), .count (count_s), .count_valid (valid_s),
    .busy (busy_s), .overflow (ovf_s)
  );

  // Square-wave generator, updated just after each falling edge; per==0 leaves sig alone.
  initial begin
    forever begin
      @(negedge clk_in);
      #1;
      if (per_a != 0) begin
        ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        sig_a = (ph_a < per_a / 2);
      end
      if (per_s != 0) begin
        ph_s  = (ph_s + 1 >= per_s) ? 0 : ph_s + 1;
        sig_s = (ph_s < per_s / 2);
      end
    end
  end

  always @(negedge clk_in) if (valid_a) vld_a++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_valid_a(input int budget, output int w);
    w = 0;
    while (w < budget) begin
      @(negedge clk_in);
      w++;
      if (valid_a) break;
    end
  endtask

  task automatic wait_valid_s(input int budget, output int w);
    w = 0;
    while (w < budget) begin
      @(negedge clk_in);
      w++;
      if (valid_s) break;
    end
  endtask

  // Start pulse on instance a: raised on this negedge, dropped on the next.
  task automatic kick_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  initial begin
    reset_n_a = 1'b0; sig_a = 1'b0; start_a = 1'b0; cont_a = 1'b0;
    reset_n_s = 1'b0; sig_s = 1'b0; start_s = 1'b0; cont_s = 1'b0;
    tick(3);
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovf", ovf_a, 0);
    reset_n_a = 1'b1;
    reset_n_s = 1'b1;

    // Single window, period 4; a start mid-window must not be queued.
    per_a = 4;
    tick(20);
    kick_a();
    check("p4_busy", busy_a, 1);
    tick(499);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_valid_a(3000, waited);
    check("p4_latency", waited, 500);
    check("p4_count", count_a, 250);
    check("p4_ovf", ovf_a, 0);
    check("p4_busy_after", busy_a, 0);
    tick(1);
    check("p4_valid_pulse", valid_a, 0);
    snap = vld_a;
    tick(1100);
    check("p4_no_requeue", vld_a - snap, 0);
    check("p4_idle", busy_a, 0);

    // Repeated start while busy, then reset at cycle 500 of the window.
    kick_a();
    tick(99);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(99);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(299);
    reset_n_a = 1'b0;
    tick(1);
    check("rst_mid_count", count_a, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_ovf", ovf_a, 0);
    reset_n_a = 1'b1;
    snap = vld_a;
    tick(1500);
    check("rst_mid_no_valid", vld_a - snap, 0);

    // Continuous mode, period 8; drop continuous mid-window.
    per_a = 8;
    tick(20);
    cont_a = 1'b1;
    kick_a();
    wait_valid_a(3000, waited);
    check("cont_lat0", waited, 1000);
    check("cont_cnt0", count_a, 125);
    wait_valid_a(3000, waited);
    check("cont_gap1", waited, 1000);
    check("cont_cnt1", count_a, 125);
    tick(300);
    cont_a = 1'b0;
    wait_valid_a(3000, waited);
    check("cont_gap_last", waited, 700);
    check("cont_cnt_last", count_a, 125);
    check("cont_busy_end", busy_a, 0);
    tick(1);
    snap = vld_a;
    tick(1200);
    check("cont_stopped", vld_a - snap, 0);

    // Held low, then held high: a level change before start is not an edge.
    per_a = 0;
    sig_a = 1'b0;
    tick(20);
    kick_a();
    wait_valid_a(3000, waited);
    check("hold0_count", count_a, 0);
    sig_a = 1'b1;
    tick(20);
    kick_a();
    wait_valid_a(3000, waited);
    check("hold1_lat", waited, 1000);
    check("hold1_count", count_a, 0);

    // Narrow counter saturates, then recovers on a slower signal.
    per_s = 4;
    tick(20);
    start_s = 1'b1; tick(1); start_s = 1'b0;
    wait_valid_s(500, waited);
    check("s_lat", waited, 100);
    check("s_sat_count", count_s, 15);
    check("s_sat_ovf", ovf_s, 1);
    per_s = 40;
    tick(50);
    start_s = 1'b1; tick(1); start_s = 1'b0;
    wait_valid_s(500, waited);
    check("s_p40_range", (count_s == 4'd2 || count_s == 4'd3), 1);
    check("s_p40_ovf", ovf_s, 0);

    // Boundary: rise pulse on the final cycle of window 1 (continuous).
    per_s = 0;
    tick(2);
    sig_s = 1'b0;
    tick(10);
    cont_s  = 1'b1;
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;                 // N1
    tick(9);  sig_s = 1'b1;         // N10 -> rise sampled at edge 12
    tick(10); sig_s = 1'b0;         // N20
    tick(78); sig_s = 1'b1;         // N98 -> rise sampled at edge 100 (last)
    tick(3);                        // N101
    check("bnd_valid1", valid_s, 1);
    check("bnd_count1", count_s, 2);
    tick(9);  sig_s = 1'b0;         // N110
    tick(40); sig_s = 1'b1;         // N150 -> rise at edge 152
    tick(10); sig_s = 1'b0;         // N160
    cont_s = 1'b0;
    tick(41);                       // N201
    check("bnd_valid2", valid_s, 1);
    check("bnd_count2", count_s, 1);
    check("bnd_busy_end", busy_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
